// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers: Gray conversion and depth.
package fifo_pkg;

    localparam int MAX_W = 32;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Callers zero-extend into MAX_W and truncate the result back to their width.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Reset-clearable multi-flop synchroniser for a Gray-coded pointer bus.
module ptr_sync #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of a dual-clock FIFO: pointers, full/almost_full,
// pessimistic fill level and sticky overflow.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              w_clk,
    input  logic              wrst_n,
    input  logic              w_en,
    input  logic [ADDR_W:0]   g_rptr_async,
    input  logic [ADDR_W:0]   afull_thresh,
    input  logic              clr_ovf,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_push,
    output logic [ADDR_W:0]   g_wptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   w_level,
    output logic              overflow
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] b_wptr, b_next, g_next;
    logic [PW-1:0] rq_sync, rb, lvl_next;
    logic          full_next;

    ptr_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (wrst_n),
        .d     (g_rptr_async),
        .q     (rq_sync)
    );

    // Held reset also blocks RAM writes, so nothing lands while the pointers are cleared.
    assign w_push = w_en & ~full & wrst_n;
    assign w_addr = b_wptr[ADDR_W-1:0];

    assign b_next    = b_wptr + PW'(w_push);
    assign g_next    = PW'(bin2gray(MAX_W'(b_next)));
    assign rb        = PW'(gray2bin(MAX_W'(rq_sync)));
    assign lvl_next  = b_next - rb;
    // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
    assign full_next = (g_next == {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]});

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            w_level     <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            full        <= full_next;
            w_level     <= lvl_next;
            almost_full <= (lvl_next >= afull_thresh);
            overflow    <= (w_en & full) | (overflow & ~clr_ovf);
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus random traffic against a count-based model.
module tb_fifo_wr_ctrl;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 8;

    logic          w_clk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          w_en = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [PW-1:0] g_rptr_async = '0;
    logic [PW-1:0] afull_thresh = 4'd8;
    logic [AW-1:0] w_addr;
    logic          w_push;
    logic [PW-1:0] g_wptr;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] w_level;
    logic          overflow;

    fifo_wr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .w_clk        (w_clk),
        .wrst_n       (wrst_n),
        .w_en         (w_en),
        .g_rptr_async (g_rptr_async),
        .afull_thresh (afull_thresh),
        .clr_ovf      (clr_ovf),
        .w_addr       (w_addr),
        .w_push       (w_push),
        .g_wptr       (g_wptr),
        .full         (full),
        .almost_full  (almost_full),
        .w_level      (w_level),
        .overflow     (overflow)
    );

    always #5 w_clk = ~w_clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model: unbounded write/read counts; the read count is seen by the
    // write side two edges late (q1 -> q2), matching the synchroniser depth.
    int m_w, m_r, q1, q2, m_full, m_lvl, m_af, m_ovf, thresh;
    int gtab[8] = '{1, 3, 2, 6, 7, 5, 4, 12};

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_outs();
        chk("g_wptr", g_wptr, gray(m_w % 16));
        chk("full", full, m_full);
        chk("w_level", w_level, m_lvl);
        chk("almost_full", almost_full, m_af);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_push"}, w_push, 0);
        chk({tag, "_addr"}, w_addr, 0);
        chk({tag, "_gptr"}, g_wptr, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_lvl"}, w_level, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    // Called just after a falling edge; leaves the bench at the next falling edge.
    task automatic cycle(input bit we, input bit rinc, input bit clr);
        int push, occ;
        if (rinc && m_r < m_w) m_r++;
        w_en = we;
        clr_ovf = clr;
        g_rptr_async = PW'(gray(m_r % 16));
        afull_thresh = PW'(thresh);
        #1;
        chk("w_push", w_push, int'(we && m_full == 0));
        chk("w_addr", w_addr, m_w % DEPTH);
        @(posedge w_clk);
        push  = (we && m_full == 0) ? 1 : 0;
        m_ovf = (we && m_full != 0) ? 1 : (clr ? 0 : m_ovf);
        m_w   = m_w + push;
        occ   = m_w - q2;
        m_full = (occ == DEPTH) ? 1 : 0;
        m_lvl  = occ;
        m_af   = (occ >= thresh) ? 1 : 0;
        q2 = q1;
        q1 = m_r;
        @(negedge w_clk);
        check_outs();
    endtask

    // Asserts reset at the current time, releases on a falling edge.
    task automatic do_reset();
        wrst_n = 1'b0;
        w_en = 1'($urandom);
        clr_ovf = 1'b0;
        #1;
        check_zero("rst_async");
        m_w = 0; m_r = 0; q1 = 0; q2 = 0;
        m_full = 0; m_lvl = 0; m_af = 0; m_ovf = 0;
        g_rptr_async = '0;
        @(negedge w_clk);
        w_en = 1'($urandom);
        #1;
        check_zero("rst_held");
        @(negedge w_clk);
        wrst_n = 1'b1;
        cycle(0, 0, 0);
    endtask

    initial begin
        thresh = 8;
        @(negedge w_clk);
        do_reset();
        chk("rst_first_full", full, 0);

        thresh = 6;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0);
            chk("g_seq", g_wptr, gtab[i]);
            chk("af_rise", almost_full, (i >= 5) ? 1 : 0);
        end
        chk("full_at8", full, 1);
        chk("lvl_at8", w_level, 8);

        cycle(1, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("g_hold", g_wptr, 12);
        cycle(0, 0, 0);
        chk("ovf_hold", overflow, 1);
        cycle(0, 0, 1);
        chk("ovf_clr", overflow, 0);
        cycle(1, 0, 1);
        chk("ovf_set_wins", overflow, 1);
        cycle(0, 0, 1);
        chk("ovf_clr2", overflow, 0);

        cycle(0, 1, 0);
        chk("rel_e1", full, 1);
        cycle(0, 0, 0);
        chk("rel_e2", full, 1);
        cycle(0, 0, 0);
        chk("rel_e3_full", full, 0);
        chk("rel_e3_lvl", w_level, 7);
        cycle(1, 0, 0);
        chk("refill", full, 1);

        repeat (3) cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);
        chk("af_fall", almost_full, 0);
        chk("lvl5", w_level, 5);

        thresh = 8;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(1, (m_w - m_r) > 3, 0);
            chk("trail_nofull", full, 0);
        end
        chk("wrap_gptr", g_wptr, 12);
        chk("wrap_addr", w_addr, 0);

        for (int i = 0; i < 8 && (m_w - m_r) < 5; i++) cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        chk("pre_rst_lvl", w_level, 5);
        #2;
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 5) thresh = $urandom_range(9);
            if ($urandom_range(199) == 0) begin
                #3;
                do_reset();
            end else begin
                cycle($urandom_range(9) < 7, 1'($urandom), $urandom_range(9) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
